// File: rtl/ddr_game_ctrl.sv
// ddr_game_ctrl: game sequencer for the DDR datapath.
// Owns the IDLE/GAME/PAUSE state and generates the pseudo-random arrow stream.
// It judges the presses collected between metronome beats against the arrow
// that sat in the hit slot, and keeps the score and combo counters.

module ddr_game_ctrl #(
  parameter int          STATE_BITS      = 1,
  parameter int          NUM_ARROWS_BITS = 4,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1,
  parameter int          BEATS_PER_SONG  = 64,
  parameter int          SCORE_MAX       = 9999
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       metronome_clk,
  input  logic                       btn_start,
  input  logic                       btn_pause,
  input  logic                       btn_sel,
  input  logic [3:0]                 btn_dir,
  input  logic [NUM_ARROWS_BITS:0]   cur_arrow,
  output logic [STATE_BITS:0]        state,
  output logic [NUM_ARROWS_BITS:0]   next_arrow,
  output logic [13:0]                score,
  output logic [13:0]                comboCount,
  output logic                       combo_enable,
  output logic                       song_done
);

  localparam int SW = STATE_BITS + 1;
  localparam int AW = NUM_ARROWS_BITS + 1;
  localparam int CW = $clog2(BEATS_PER_SONG + 1);

  localparam logic [AW-1:0] ARROW_NONE = AW'(20);
  localparam logic [13:0]   SAT        = 14'(SCORE_MAX);
  localparam logic [CW-1:0] SONG_LEN   = CW'(BEATS_PER_SONG);

  typedef enum logic [STATE_BITS:0] {
    IDLE  = SW'(0),
    GAME  = SW'(1),
    PAUSE = SW'(2)
  } state_t;

  state_t          cur_state;
  logic            meta_q;
  logic            sync_q;
  logic            sync_d;
  logic            beat;
  logic            beat_d1;
  logic            beat_d2;
  logic [15:0]     lfsr;
  logic [3:0]      press_mask;
  logic [AW-1:0]   target;
  logic [CW-1:0]   beat_cnt;

  logic [3:0]      exp_mask;
  logic            hit;
  logic            quiet;
  logic            new_game;
  logic [15:0]     lfsr_next;
  logic [AW-1:0]   gen_arrow;
  logic [13:0]     score_up;
  logic [13:0]     combo_up;
  logic [CW-1:0]   cnt_next;

  assign state = cur_state;

  // Bring the metronome into clk, edge-detect it, and delay the beat so the target is captured after the display shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      sync_d  <= 1'b0;
      beat    <= 1'b0;
      beat_d1 <= 1'b0;
      beat_d2 <= 1'b0;
    end else begin
      meta_q  <= metronome_clk;
      sync_q  <= meta_q;
      sync_d  <= sync_q;
      beat    <= sync_q & ~sync_d;
      beat_d1 <= beat && (cur_state == GAME);
      beat_d2 <= beat_d1;
    end
  end

  // Judgement, arrow generation and saturating counter helpers.
  always_comb begin
    exp_mask = 4'b0000;
    case (target)
      AW'(10): exp_mask = 4'b1000;
      AW'(11): exp_mask = 4'b0100;
      AW'(12): exp_mask = 4'b0010;
      AW'(13): exp_mask = 4'b0001;
      AW'(14): exp_mask = 4'b1100;
      AW'(15): exp_mask = 4'b1010;
      AW'(16): exp_mask = 4'b1001;
      AW'(17): exp_mask = 4'b0110;
      AW'(18): exp_mask = 4'b0101;
      AW'(19): exp_mask = 4'b0011;
      default: exp_mask = 4'b0000;
    endcase
    hit       = (press_mask == exp_mask) && (target != ARROW_NONE);
    quiet     = (target == ARROW_NONE) && (press_mask == 4'b0000);
    new_game  = btn_start && ((cur_state == IDLE) || (cur_state == PAUSE));
    lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    gen_arrow = (lfsr[15:12] == 4'd0) ? ARROW_NONE : (AW'(10) + AW'(lfsr[3:0] % 4'd10));
    score_up  = (score >= SAT) ? SAT : score + 14'd1;
    combo_up  = (comboCount >= SAT) ? SAT : comboCount + 14'd1;
    cnt_next  = beat_cnt + 1'b1;
  end

  // Game state machine with all registered outputs, scoring and the arrow LFSR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state    <= IDLE;
      score        <= 14'd0;
      comboCount   <= 14'd0;
      combo_enable <= 1'b0;
      song_done    <= 1'b0;
      next_arrow   <= ARROW_NONE;
      lfsr         <= LFSR_SEED;
      beat_cnt     <= '0;
      press_mask   <= 4'b0000;
      target       <= ARROW_NONE;
    end else begin
      if (beat_d2) begin
        target <= cur_arrow;
      end
      if (beat_d1 && (cur_state == GAME)) begin
        next_arrow <= gen_arrow;
      end
      if (new_game) begin
        cur_state    <= GAME;
        score        <= 14'd0;
        comboCount   <= 14'd0;
        combo_enable <= 1'b0;
        song_done    <= 1'b0;
        beat_cnt     <= '0;
        press_mask   <= 4'b0000;
        target       <= ARROW_NONE;
      end else begin
        case (cur_state)
          GAME: begin
            if (beat) begin
              if (hit) begin
                score      <= score_up;
                comboCount <= combo_up;
              end else if (!quiet) begin
                comboCount <= 14'd0;
              end
              press_mask <= btn_dir;
              lfsr       <= lfsr_next;
              beat_cnt   <= cnt_next;
              if (cnt_next == SONG_LEN) begin
                cur_state <= PAUSE;
                song_done <= 1'b1;
              end else if (btn_pause) begin
                cur_state <= PAUSE;
              end
            end else begin
              press_mask <= press_mask | btn_dir;
              if (btn_pause) begin
                cur_state <= PAUSE;
              end
            end
          end
          PAUSE: begin
            if (btn_pause && !song_done) begin
              cur_state <= GAME;
            end
            if (btn_sel) begin
              combo_enable <= ~combo_enable;
            end
          end
          IDLE: begin
            cur_state <= IDLE;
          end
          default: begin
            cur_state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ddr_game_ctrl.sv
// tb_ddr_game_ctrl: directed bench for ddr_game_ctrl with a scoreboard of expected judgements.
// dut runs with default parameters; dut2 shares every input but has a 4-beat song and a score ceiling of 2.

module tb_ddr_game_ctrl;

  logic        clk;
  logic        rst;
  logic        metronome_clk;
  logic        btn_start;
  logic        btn_pause;
  logic        btn_sel;
  logic [3:0]  btn_dir;
  logic [4:0]  cur_arrow;

  logic [1:0]  state;
  logic [4:0]  next_arrow;
  logic [13:0] score;
  logic [13:0] comboCount;
  logic        combo_enable;
  logic        song_done;

  logic [1:0]  state2;
  logic [4:0]  next_arrow2;
  logic [13:0] score2;
  logic [13:0] comboCount2;
  logic        combo_enable2;
  logic        song_done2;

  int checkCount;
  int passCount;

  int          mScore;
  int          mCombo;
  int          m2Score;
  int          m2Combo;
  int          mTarget;
  logic [15:0] mLfsr;

  string tagQ[$];
  int    expScoreQ[$];
  int    expComboQ[$];
  bit    dutSelQ[$];
  int    arrowQ[$];

  ddr_game_ctrl dut (
    .clk(clk), .rst(rst), .metronome_clk(metronome_clk),
    .btn_start(btn_start), .btn_pause(btn_pause), .btn_sel(btn_sel),
    .btn_dir(btn_dir), .cur_arrow(cur_arrow),
    .state(state), .next_arrow(next_arrow), .score(score),
    .comboCount(comboCount), .combo_enable(combo_enable), .song_done(song_done)
  );

  ddr_game_ctrl #(.BEATS_PER_SONG(4), .SCORE_MAX(2)) dut2 (
    .clk(clk), .rst(rst), .metronome_clk(metronome_clk),
    .btn_start(btn_start), .btn_pause(btn_pause), .btn_sel(btn_sel),
    .btn_dir(btn_dir), .cur_arrow(cur_arrow),
    .state(state2), .next_arrow(next_arrow2), .score(score2),
    .comboCount(comboCount2), .combo_enable(combo_enable2), .song_done(song_done2)
  );

  // Free-running system clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
  endtask

  function automatic logic [15:0] lfsrStep(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic int arrowOf(input logic [15:0] v);
    if (v[15:12] == 4'd0) return 20;
    return 10 + (int'(v[3:0]) % 10);
  endfunction

  function automatic logic [3:0] arrowMask(input int code);
    case (code)
      10: return 4'b1000;
      11: return 4'b0100;
      12: return 4'b0010;
      13: return 4'b0001;
      14: return 4'b1100;
      15: return 4'b1010;
      16: return 4'b1001;
      17: return 4'b0110;
      18: return 4'b0101;
      19: return 4'b0011;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic modelJudge(input logic [3:0] mask, input int maxv, inout int s, inout int c);
    if ((mask == arrowMask(mTarget)) && (mTarget != 20)) begin
      if (s < maxv) s = s + 1;
      if (c < maxv) c = c + 1;
    end else if (!((mTarget == 20) && (mask == 4'b0000))) begin
      c = 0;
    end
  endtask

  task automatic pulse(input bit doStart, input bit doPause, input bit doSel);
    btn_start = doStart;
    btn_pause = doPause;
    btn_sel   = doSel;
    tick();
    btn_start = 1'b0;
    btn_pause = 1'b0;
    btn_sel   = 1'b0;
  endtask

  task automatic modelNewGame();
    mScore  = 0;
    mCombo  = 0;
    m2Score = 0;
    m2Combo = 0;
    mTarget = 20;
  endtask

  // Press the requested directions one at a time, queue the expected outcome, then play one metronome beat.
  task automatic applyStimulus(input string tag, input logic [3:0] dirs, input bit pauseAtBeat,
                               input bit trackDut2, input bit chkArrow);
    for (int b = 3; b >= 0; b--) begin
      if (dirs[b]) begin
        btn_dir    = 4'b0000;
        btn_dir[b] = 1'b1;
        tick();
        btn_dir = 4'b0000;
      end
    end
    modelJudge(dirs, 9999, mScore, mCombo);
    tagQ.push_back(tag);
    expScoreQ.push_back(mScore);
    expComboQ.push_back(mCombo);
    dutSelQ.push_back(1'b0);
    if (trackDut2) begin
      modelJudge(dirs, 2, m2Score, m2Combo);
      tagQ.push_back({tag, ".d2"});
      expScoreQ.push_back(m2Score);
      expComboQ.push_back(m2Combo);
      dutSelQ.push_back(1'b1);
    end
    mLfsr = lfsrStep(mLfsr);
    if (chkArrow) arrowQ.push_back(arrowOf(mLfsr));
    metronome_clk = 1'b1;
    repeat (3) tick();
    btn_pause = pauseAtBeat;
    tick();
    btn_pause = 1'b0;
    repeat (2) tick();
    metronome_clk = 1'b0;
    repeat (3) tick();
    mTarget = int'(cur_arrow);
  endtask

  // Pop every queued expectation and compare it with what the DUTs now show.
  task automatic checkOutput();
    string tag;
    int    es;
    int    ec;
    bit    sel;
    int    ea;
    while (tagQ.size() > 0) begin
      tag = tagQ.pop_front();
      es  = expScoreQ.pop_front();
      ec  = expComboQ.pop_front();
      sel = dutSelQ.pop_front();
      if (sel) begin
        check({tag, ".score"}, 32'(score2), es);
        check({tag, ".combo"}, 32'(comboCount2), ec);
      end else begin
        check({tag, ".score"}, 32'(score), es);
        check({tag, ".combo"}, 32'(comboCount), ec);
      end
    end
    while (arrowQ.size() > 0) begin
      ea = arrowQ.pop_front();
      check("next_arrow", 32'(next_arrow), ea);
      check("arrowRange", 32'((next_arrow >= 5'd10) && (next_arrow <= 5'd20)), 1);
    end
  endtask

  // Directed sequence: reset, LFSR stream, hits, misses, reset mid-game, pause/resume, song end and saturation.
  initial begin
    checkCount    = 0;
    passCount     = 0;
    rst           = 1'b1;
    metronome_clk = 1'b0;
    btn_start     = 1'b0;
    btn_pause     = 1'b0;
    btn_sel       = 1'b0;
    btn_dir       = 4'b0000;
    cur_arrow     = 5'd20;
    mLfsr         = 16'hACE1;
    modelNewGame();
    repeat (2) tick();
    check("rst.state", 32'(state), 0);
    check("rst.score", 32'(score), 0);
    check("rst.combo", 32'(comboCount), 0);
    check("rst.next_arrow", 32'(next_arrow), 20);
    check("rst.song_done", 32'(song_done), 0);
    check("rst.combo_enable", 32'(combo_enable), 0);
    rst = 1'b0;
    tick();
    pulse(1'b1, 1'b0, 1'b0);
    check("start.state", 32'(state), 1);

    for (int i = 0; i < 8; i++) begin
      applyStimulus("lfsr", 4'b0000, 1'b0, 1'b0, 1'b1);
      checkOutput();
    end

    cur_arrow = 5'd15;
    applyStimulus("hitPrime", 4'b0000, 1'b0, 1'b0, 1'b0);
    checkOutput();
    for (int i = 0; i < 3; i++) begin
      applyStimulus("hitUL", 4'b1010, 1'b0, 1'b0, 1'b0);
      checkOutput();
    end
    check("hit3.score", 32'(score), 3);

    cur_arrow = 5'd10;
    applyStimulus("hitUL2", 4'b1010, 1'b0, 1'b0, 1'b0);
    checkOutput();
    applyStimulus("missD", 4'b0100, 1'b0, 1'b0, 1'b0);
    checkOutput();
    cur_arrow = 5'd20;
    applyStimulus("hitU", 4'b1000, 1'b0, 1'b0, 1'b0);
    checkOutput();
    applyStimulus("noneQuiet", 4'b0000, 1'b0, 1'b0, 1'b0);
    checkOutput();
    applyStimulus("noneR", 4'b0001, 1'b0, 1'b0, 1'b0);
    checkOutput();
    check("preReset.score", 32'(score), 5);

    rst = 1'b1;
    #1;
    check("asyncRst.state", 32'(state), 0);
    check("asyncRst.score", 32'(score), 0);
    check("asyncRst.next_arrow", 32'(next_arrow), 20);
    check("asyncRst.combo_enable", 32'(combo_enable), 0);
    tick();
    rst = 1'b0;
    mLfsr = 16'hACE1;
    modelNewGame();
    tick();
    pulse(1'b1, 1'b0, 1'b0);
    check("restart.state", 32'(state), 1);

    cur_arrow = 5'd12;
    applyStimulus("pausePrime", 4'b0000, 1'b0, 1'b0, 1'b0);
    checkOutput();
    applyStimulus("pauseBeatL", 4'b0010, 1'b1, 1'b0, 1'b0);
    checkOutput();
    check("pauseBeat.state", 32'(state), 2);
    pulse(1'b0, 1'b0, 1'b1);
    check("sel.combo_enable", 32'(combo_enable), 1);
    pulse(1'b0, 1'b1, 1'b0);
    check("resume.state", 32'(state), 1);
    check("resume.score", 32'(score), 1);
    check("resume.combo", 32'(comboCount), 1);
    pulse(1'b0, 1'b1, 1'b0);
    check("repause.state", 32'(state), 2);
    pulse(1'b1, 1'b1, 1'b0);
    modelNewGame();
    check("startWins.state", 32'(state), 1);
    check("startWins.score", 32'(score), 0);
    check("startWins.combo", 32'(comboCount), 0);
    check("startWins.combo_enable", 32'(combo_enable), 0);

    cur_arrow = 5'd13;
    applyStimulus("songPrime", 4'b0000, 1'b0, 1'b1, 1'b0);
    checkOutput();
    for (int i = 0; i < 3; i++) begin
      applyStimulus("satR", 4'b0001, 1'b0, 1'b1, 1'b0);
      checkOutput();
    end
    check("songEnd.state2", 32'(state2), 2);
    check("songEnd.song_done2", 32'(song_done2), 1);
    check("songEnd.state", 32'(state), 1);
    check("songEnd.song_done", 32'(song_done), 0);
    pulse(1'b0, 1'b1, 1'b0);
    check("pauseIgnored.state2", 32'(state2), 2);
    check("pauseIgnored.song_done2", 32'(song_done2), 1);
    pulse(1'b1, 1'b0, 1'b0);
    check("songRestart.state2", 32'(state2), 1);
    check("songRestart.song_done2", 32'(song_done2), 0);
    check("songRestart.beat_cnt2", 32'(dut2.beat_cnt), 0);
    check("songRestart.score2", 32'(score2), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
